instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the single-cycle MIPS core's decode/execute path.
- Issues sequential word fetches to instruction memory over a req/ack handshake and buffers returned words in a small prefetch FIFO.
- Presents instructions to the core with a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush and discard of any in-flight fetch.

Parameters:
- ADDR_W, 6, PC/byte-address width; PC wraps modulo 2^ADDR_W.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low. rst=0 resets immediately; release is sampled on clk.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  ADDR_W  byte address of the request; always word aligned.
- mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  fetched instruction word.
- redirect  in  1  one-cycle pulse that loads a new fetch PC and flushes the queue.
- redirect_pc  in  ADDR_W  target address; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  FIFO head is valid.
- instr  out  32  FIFO head word.
- instr_pc  out  ADDR_W  address of the FIFO head word.
- instr_ready  in  1  core consumes the head when instr_valid && instr_ready.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; FIFO empty.
  - mem_req=0, mem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - FSM=IDLE.
- FSM states: IDLE (no request outstanding), REQ (request outstanding), DISCARD (outstanding request already flushed).
- IDLE -> REQ when count + 0 < DEPTH and no redirect this cycle.
  - mem_req asserts the next cycle, with mem_addr=fetch_pc.
- REQ holds mem_req=1 and mem_addr stable until mem_ack=1. In the ack cycle:
  - write {mem_rdata, mem_addr} to the FIFO tail;
  - fetch_pc += 4, wrapping modulo 2^ADDR_W;
  - go to REQ if count_after + 1 <= DEPTH-1 (room remains), else IDLE.
  - Back-to-back requests are therefore allowed: one fetch per cycle when memory acks every cycle.
- Credit rule: a request is issued only if count + outstanding < DEPTH. An ack can never find the FIFO full.
- Pop: head advances when instr_valid && instr_ready.
  - instr, instr_valid and instr_pc are driven from registered FIFO storage, with no combinational path from mem_rdata.
  - Write latency: mem_ack cycle -> instr_valid the next cycle.
  - Simultaneous push and pop in one cycle keeps count unchanged.
- Redirect (highest priority, synchronous):
  - FIFO is cleared and fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - instr_valid is forced 0 in the redirect cycle; no pop takes effect that cycle.
  - If in REQ without ack this cycle: go to DISCARD. mem_req stays 1 with the old address until ack; the acked data is dropped; then go to REQ for the new PC.
  - If ack coincides with redirect: the data is dropped, and the new-PC request asserts the next cycle.
  - Redirect while in DISCARD: only fetch_pc is updated; stay in DISCARD.
- mem_ack while mem_req=0 is ignored.
- Asserting rst mid-transfer aborts immediately. Memory must tolerate a dropped request.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three outputs:
  - fetch_cnt[15:0]: increments on every accepted, non-discarded ack;
  - flush_cnt[15:0]: increments on every redirect;
  - stall_cnt[15:0]: increments each cycle with mem_req=1 && mem_ack=0.
- All three counters are saturating, reset to 0 by rst, and updated on clk.
- When undefined, these ports and registers are absent and the core behaviour is identical.

Test Plan:
- Reset then stream:
  - Stimulus: rst low 3 cycles, RESET_PC=0, mem_ack=1 every cycle, instr_ready=1, mem_rdata=0x1000_0000|addr.
  - Required: mem_addr sequence 0,4,8,...; instr_pc follows one cycle after each ack; no gaps.
- Backpressure fill:
  - Stimulus: instr_ready=0, mem_ack=1.
  - Required: exactly 4 acks, then mem_req=0; instr held at the addr-0 word; set ready=1 -> words 0,4,8,12 in order, then fetching resumes at 16.
- Redirect mid-flight:
  - Stimulus: mem_ack held 0 while mem_req at addr 8; redirect to 0x24 (=36).
  - Required: mem_addr stays 8 until ack; that word is never presented; the next request is at 36; the FIFO was empty after redirect.
- Simultaneous redirect and ack:
  - Stimulus: ack at addr 12 with redirect_pc=0x13.
  - Required: word 12 dropped; the next mem_addr is 0x10 (low bits cleared).
- Wrap-around:
  - Stimulus: redirect to 60 (ADDR_W=6).
  - Required: fetch addresses 60, 0, 4; instr_pc values match.
- Reset mid-operation:
  - Stimulus: rst low while mem_req=1 and FIFO holds 2 entries.
  - Required: mem_req and instr_valid drop to 0 asynchronously; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with req/ack memory handshake, prefetch FIFO and PC redirect.
// Optional fetch/flush/stall counters are enabled by defining FETCH_PERF_EN.
module instr_fetch_queue #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned       PW         = $clog2(DEPTH);
    localparam int unsigned       CW         = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, redirect_aligned;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_after;
    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              ack, push, pop;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign mem_req          = (state != IDLE);
    assign ack              = mem_req && mem_ack;
    assign push             = (state == REQ) && ack && !redirect;
    assign instr_valid      = (count != '0) && !redirect;
    assign pop              = instr_valid && instr_ready;
    assign instr            = data_mem[rd_ptr];
    assign instr_pc         = pc_mem[rd_ptr];

    always_comb begin
        count_after = count;
        if (push && !pop) begin
            count_after = count + CW'(1);
        end else if (!push && pop) begin
            count_after = count - CW'(1);
        end
    end

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            fetch_pc_nxt = redirect_aligned;
        end else if (push) begin
            fetch_pc_nxt = fetch_pc + ADDR_W'(4);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!redirect && (count < DEPTH_C)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nxt = (redirect || (count_after < DEPTH_C - CW'(1))) ? REQ : IDLE;
                end else if (redirect) begin
                    state_nxt = DISCARD;
                end
            end
            // An ack here closes the flushed request; a coincident redirect is
            // already captured in fetch_pc_nxt, so the fresh request uses it.
            DISCARD: begin
                if (ack) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_ADDR;
            mem_addr <= RESET_ADDR;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            // The address of a pending request is frozen until it is acked.
            if (!(mem_req && !mem_ack)) begin
                mem_addr <= fetch_pc_nxt;
            end
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count_after;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= mem_addr;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
            if (mem_req && !mem_ack && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed scenarios plus a randomized phase for instr_fetch_queue, checked against
// a transaction-level model (queue of expected words, expected fetch PC, flushed-request flag).
module tb_instr_fetch_queue;

    localparam int unsigned AW = 6;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;

    instr_fetch_queue #(
        .ADDR_W  (AW),
        .DEPTH   (DP),
        .RESET_PC(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   data;
    } entry_t;

    entry_t        q[$];
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] held_addr;
    logic          tainted;
    logic          exp_req;
    logic          stream_data;
    int            n_tests = 0;
    int            n_fail  = 0;

    logic          obs_req, obs_valid;
    logic [AW-1:0] obs_addr, obs_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_pc    = '0;
        held_addr = '0;
        tainted   = 1'b0;
        exp_req   = 1'b0;
    endtask

    // Caller drives inputs at the falling edge; this checks, advances the model and one clock.
    task automatic step();
        logic          ack_eff, pop, exp_valid, was_t, nreq;
        logic [AW-1:0] cur_addr;
        int unsigned   sz;
        mem_rdata = stream_data ? (32'h1000_0000 | 32'(mem_addr)) : $urandom;
        #1;
        sz        = q.size();
        exp_valid = (sz != 0) && !redirect;
        cur_addr  = tainted ? held_addr : exp_pc;
        check("mem_req", mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_addr, cur_addr);
        check("instr_valid", instr_valid, exp_valid);
        if (exp_valid) begin
            check("instr", instr, q[0].data);
            check("instr_pc", instr_pc, q[0].pc);
        end
        check("credit", ((sz + (exp_req ? 1 : 0)) <= DP), 1'b1);
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;

        ack_eff = exp_req && mem_ack;
        pop     = exp_valid && instr_ready;
        was_t   = tainted;
        if (redirect) begin
            q.delete();
            exp_pc = {redirect_pc[AW-1:2], 2'b00};
            if (exp_req && !ack_eff) begin
                held_addr = cur_addr;
                tainted   = 1'b1;
            end else begin
                tainted = 1'b0;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (ack_eff) begin
                if (tainted) begin
                    tainted = 1'b0;
                end else begin
                    q.push_back('{pc: cur_addr, data: mem_rdata});
                    exp_pc = exp_pc + 6'd4;
                end
            end
        end
        if (!exp_req)               nreq = !redirect && (sz < DP);
        else if (!ack_eff)          nreq = 1'b1;
        else if (redirect || was_t) nreq = 1'b1;
        else                        nreq = (q.size() + 1 <= DP - 1);
        exp_req = nreq;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto_pc(input logic [AW-1:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        mem_ack     = 1'b1;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int          acks;
        logic        found;
        logic [AW-1:0] ack_addrs[$];
        logic [AW-1:0] pop_pcs[$];

        rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0; stream_data = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 6'd0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 6'd0);
        rst = 1'b1;

        // Streaming with memory acking every cycle
        mem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 2) check("stream_no_gap", obs_valid, 1'b1);
        end

        // Backpressure fill then drain
        goto_pc(6'd0);
        instr_ready = 1'b0; acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req && mem_ack) acks++;
            step();
        end
        check("bp_ack_count", acks, 4);
        check("bp_req_low", mem_req, 1'b0);
        check("bp_head_pc", instr_pc, 6'd0);
        instr_ready = 1'b1; mem_ack = 1'b0;
        pop_pcs.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_valid) pop_pcs.push_back(obs_pc);
        end
        check("bp_pop_count", pop_pcs.size(), 4);
        for (int i = 0; i < 4 && i < pop_pcs.size(); i++) check("bp_pop_order", pop_pcs[i], 6'(4 * i));
        check("bp_resume_req", mem_req, 1'b1);
        check("bp_resume_addr", mem_addr, 6'd16);

        // Redirect while a request at 8 is stalled
        mem_ack = 1'b1;
        goto_pc(6'd0);
        instr_ready = 1'b0; found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req && mem_addr == 6'd8) begin
                found = 1'b1;
                break;
            end
            mem_ack = 1'b1;
            step();
        end
        check("reach_addr8", found, 1'b1);
        mem_ack = 1'b0;
        step(); step();
        redirect = 1'b1; redirect_pc = 6'd36;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("discard_req", obs_req, 1'b1);
            check("discard_addr", obs_addr, 6'd8);
            check("discard_flushed", obs_valid, 1'b0);
        end
        mem_ack = 1'b1;
        step();
        instr_ready = 1'b1;
        step();
        check("redir_new_addr", obs_addr, 6'd36);
        step();
        check("redir_head_pc", obs_pc, 6'd36);

        // Redirect coinciding with ack at 12
        goto_pc(6'd0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req && mem_addr == 6'd12) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("reach_addr12", found, 1'b1);
        redirect = 1'b1; redirect_pc = 6'h13; mem_ack = 1'b1;
        step();
        redirect = 1'b0;
        step();
        check("coinc_req", obs_req, 1'b1);
        check("coinc_addr", obs_addr, 6'h10);
        step(); step();

        // Wrap-around from 60
        goto_pc(6'd60);
        ack_addrs.delete(); pop_pcs.delete();
        for (int i = 0; i < 6; i++) begin
            if (mem_req) ack_addrs.push_back(mem_addr);
            step();
            if (obs_valid) pop_pcs.push_back(obs_pc);
        end
        check("wrap_acks", ack_addrs.size() >= 3, 1'b1);
        check("wrap_pops", pop_pcs.size() >= 3, 1'b1);
        if (ack_addrs.size() >= 3 && pop_pcs.size() >= 3) begin
            check("wrap_a0", ack_addrs[0], 6'd60);
            check("wrap_a1", ack_addrs[1], 6'd0);
            check("wrap_a2", ack_addrs[2], 6'd4);
            check("wrap_p0", pop_pcs[0], 6'd60);
            check("wrap_p1", pop_pcs[1], 6'd0);
            check("wrap_p2", pop_pcs[2], 6'd4);
        end

        // Asynchronous reset with a request pending and two entries buffered
        goto_pc(6'd0);
        instr_ready = 1'b0; mem_ack = 1'b1;
        step(); step();
        check("pre_rst_req", mem_req, 1'b1);
        check("pre_rst_valid", instr_valid, 1'b1);
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_valid", instr_valid, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;
        model_reset();
        mem_ack = 1'b1; instr_ready = 1'b1;
        step(); step();
        check("restart_req", obs_req, 1'b1);
        check("restart_addr", obs_addr, 6'd0);

        // Randomized traffic
        stream_data = 1'b0;
        for (int i = 0; i < 400; i++) begin
            mem_ack     = ($urandom % 10) < 6;
            instr_ready = ($urandom % 10) < 7;
            redirect    = ($urandom % 100) < 8;
            redirect_pc = 6'($urandom_range(0, 63));
            step();
        end
        redirect = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
